// File: rtl/bitmask_sched.sv
// rtl/bitmask_sched.sv - essential-bit scheduler: emits set-bit positions of a 16-bit mask, MSB first
//
// Purpose : accepts one 16-bit operand bitmask per word and emits the priority
//           index of each set bit (index 0 = bit 15) as one beat per cycle on a
//           valid/ready stream, capped at MAX_BITS beats per word.
// Ports   : clk, reset (async, active-high)
//           in_valid / in_ready / in_bitmask[15:0]      word input stream
//           out_valid / out_ready / out_idx[3:0] /
//           out_val / out_last                          beat output stream
//           busy                                        high while a word is in flight
// Config  : BITMASK_SCHED_EMPTY_BEAT_EN - when defined, a zero word yields one
//           beat with out_val=0 and out_last=1; otherwise it is silently consumed.
module bitmask_sched #(
    parameter int MAX_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bitmask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_val,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] CNT_LAST = 5'(MAX_BITS - 1);

    state_t      state, state_nxt;
    logic [15:0] mask_r;
    logic [4:0]  cnt_r;
    logic [3:0]  enc_idx;
    logic        mask_nz, mask_one;
    logic        accept, fire, in_zero;

    // Highest set bit wins: later iterations override earlier ones.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (mask_r[i]) enc_idx = 4'(15 - i);
        end
    end

    assign mask_nz  = |mask_r;
    assign mask_one = mask_nz && ((mask_r & (mask_r - 16'd1)) == 16'd0);
    assign in_zero  = (in_bitmask == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        out_valid = 1'b0;
        out_idx   = '0;
        out_val   = 1'b0;
        out_last  = 1'b0;
        state_nxt = state;
        // Outputs are gated by state so a word truncated by the cap leaves no
        // stale index visible once back in IDLE.
        if (state == RUN) begin
            out_valid = 1'b1;
            out_idx   = enc_idx;
            out_val   = mask_nz;
            out_last  = mask_one || (cnt_r == CNT_LAST) || !mask_nz;
        end
        fire     = out_valid && out_ready;
        in_ready = (state == IDLE) || (fire && out_last);
        accept   = in_valid && in_ready;
        if (fire && out_last) state_nxt = IDLE;
        // Acceptance only happens in IDLE or on the retiring beat, so it may
        // override the return to IDLE for gap-free back-to-back words.
        if (accept) begin
            if (!in_zero) state_nxt = RUN;
            else begin
`ifdef BITMASK_SCHED_EMPTY_BEAT_EN
                state_nxt = RUN;
`else
                state_nxt = IDLE;
`endif
            end
        end
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= '0;
            cnt_r  <= '0;
        end else if (accept) begin
            mask_r <= in_bitmask;
            cnt_r  <= '0;
        end else if (fire) begin
            mask_r <= mask_r & ~(16'h8000 >> out_idx);
            cnt_r  <= cnt_r + 5'd1;
        end
    end

endmodule
